// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer for the KGP-RISC program counter: owns the PC, issues
// instruction fetches with a req/ack handshake and resolves the next PC each instruction.
module pc_sequencer #(
  parameter int                 ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]  RESET_VEC   = '0,
  parameter int                 INSTR_BYTES = 4,
  parameter int                 MAX_WAIT    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  output logic              ir_load,
  output logic              ex_valid,
  input  logic [2:0]        br_kind,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              flag_z,
  input  logic              flag_c,
  input  logic              flag_s,
  output logic              taken,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_data,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_prev,
  output logic              halted,
  output logic              fault,
  output logic [31:0]       instr_count
);

  localparam int                WCNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(INSTR_BYTES);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_HALT, S_FAULT
  } state_t;

  state_t              state, state_nx;
  logic [WCNT_W-1:0]   wait_cnt;
  logic                halt_pending;
  logic                br_taken;
  logic                misalign;
  logic [ADDR_W-1:0]   pc_seq;
  logic [ADDR_W-1:0]   pc_next;

  function automatic logic branch_taken(input logic [2:0] kind, input logic z,
                                        input logic c, input logic s);
    case (kind)
      3'd1, 3'd2, 3'd3: branch_taken = 1'b1;
      3'd4:             branch_taken = z;
      3'd5:             branch_taken = !z;
      3'd6:             branch_taken = c;
      3'd7:             branch_taken = s;
      default:          branch_taken = 1'b0;
    endcase
  endfunction

  assign br_taken  = branch_taken(br_kind, flag_z, flag_c, flag_s);
  assign misalign  = (br_target[1:0] != 2'b00);
  assign pc_seq    = pc_out + PC_STEP;
  assign pc_next   = br_taken ? br_target : pc_seq;
  assign imem_addr = pc_out;
  assign link_data = pc_seq;

  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    ir_load  = 1'b0;
    ex_valid = 1'b0;
    taken    = 1'b0;
    link_we  = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load  = 1'b1;
          state_nx = S_EXEC;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx = S_FAULT;
        end
      end
      S_EXEC: begin
        ex_valid = 1'b1;
        taken    = br_taken;
        link_we  = (br_kind == 3'd3);
        if (br_taken && misalign)          state_nx = S_FAULT;
        else if (halt_pending || halt_req) state_nx = S_HALT;
        else                               state_nx = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) state_nx = S_FETCH;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // A misaligned taken target faults without moving the PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      pc_out       <= RESET_VEC;
      pc_prev      <= RESET_VEC;
      instr_count  <= '0;
      halt_pending <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_FETCH: begin
          wait_cnt <= '0;
          if (halt_req) halt_pending <= 1'b1;
        end
        S_WAIT: begin
          if (halt_req) halt_pending <= 1'b1;
          if (!imem_ack) wait_cnt <= wait_cnt + 1'b1;
        end
        S_EXEC: begin
          pc_prev <= pc_out;
          if (!(br_taken && misalign)) pc_out <= pc_next;
          if (instr_count != 32'hFFFF_FFFF) instr_count <= instr_count + 32'd1;
          if (state_nx == S_HALT) halt_pending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, branches, link, halt, wrap,
// misalignment and timeout faults, and asynchronous reset.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, halt_req, imem_ack;
  logic        imem_req, ir_load, ex_valid, taken, link_we, halted, fault;
  logic [31:0] imem_addr, link_data, pc_out, pc_prev, instr_count, br_target;
  logic [2:0]  br_kind;
  logic        flag_z, flag_c, flag_s;
  logic [7:0]  taken_tab;

  int total = 0;
  int bad   = 0;

  pc_sequencer #(.ADDR_W(32), .RESET_VEC(32'h0), .INSTR_BYTES(4), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .ir_load(ir_load), .ex_valid(ex_valid), .br_kind(br_kind), .br_target(br_target),
    .flag_z(flag_z), .flag_c(flag_c), .flag_s(flag_s), .taken(taken),
    .link_we(link_we), .link_data(link_data), .pc_out(pc_out), .pc_prev(pc_prev),
    .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in FETCH with imem_ack=1; ends one tick into EXEC.
  task automatic fetch_one(input logic [31:0] exp_addr);
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, exp_addr);
    step();
    chk("wait_ir_load", {31'd0, ir_load}, 32'd1);
    step();
    chk("exec_valid", {31'd0, ex_valid}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; imem_ack = 1'b0;
    br_kind = 3'd0; br_target = 32'h0; flag_z = 1'b0; flag_c = 1'b0; flag_s = 1'b0;
    taken_tab = 8'b0110_1110;
    #2 rst = 1'b0;
    #1;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_pc_prev", pc_prev, 32'h0);
    chk("rst_count", instr_count, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_flags", {29'd0, halted, fault, ex_valid}, 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("idle_req", {31'd0, imem_req}, 32'd0);

    // Sequential fetch with ack tied high
    start = 1'b1; imem_ack = 1'b1;
    step();
    start = 1'b0;
    fetch_one(32'h0);
    chk("seq_taken", {31'd0, taken}, 32'd0);
    step();
    chk("seq_pc_prev0", pc_prev, 32'h0);
    chk("seq_count1", instr_count, 32'd1);
    chk("seq_exv_off", {31'd0, ex_valid}, 32'd0);
    fetch_one(32'h4);
    step();
    fetch_one(32'h8);
    step();
    chk("seq_count3", instr_count, 32'd3);
    chk("seq_pc_prev8", pc_prev, 32'h8);
    fetch_one(32'hC);
    step();

    // bz taken at 0x10
    fetch_one(32'h10);
    br_kind = 3'd4; flag_z = 1'b1; br_target = 32'h40;
    #1 chk("bz_taken", {31'd0, taken}, 32'd1);
    step();
    br_kind = 3'd0;
    chk("bz_next", imem_addr, 32'h40);
    chk("bz_pc_prev", pc_prev, 32'h10);
    fetch_one(32'h40);
    br_kind = 3'd1; br_target = 32'h10;
    step();
    br_kind = 3'd0;

    // bz not taken at 0x10
    fetch_one(32'h10);
    br_kind = 3'd4; flag_z = 1'b0; br_target = 32'h40;
    #1 chk("bz_nt", {31'd0, taken}, 32'd0);
    step();
    br_kind = 3'd0;
    chk("bz_nt_next", imem_addr, 32'h14);

    // Condition table over all kinds with z=0 c=1 s=0, then br to 0x20
    fetch_one(32'h14);
    flag_c = 1'b1; br_target = 32'h20;
    for (int k = 0; k < 8; k++) begin
      br_kind = 3'(k);
      #1 chk($sformatf("kind%0d_taken", k), {31'd0, taken}, {31'd0, taken_tab[k]});
    end
    br_kind = 3'd2; flag_c = 1'b0;
    step();
    br_kind = 3'd0;

    // bl at 0x20
    fetch_one(32'h20);
    br_kind = 3'd3; br_target = 32'h100;
    #1;
    chk("bl_we", {31'd0, link_we}, 32'd1);
    chk("bl_data", link_data, 32'h24);
    chk("bl_taken", {31'd0, taken}, 32'd1);
    step();
    br_kind = 3'd0;
    chk("bl_next", imem_addr, 32'h100);
    chk("bl_we_off", {31'd0, link_we}, 32'd0);
    fetch_one(32'h100);
    br_kind = 3'd1; br_target = 32'h8;
    step();
    br_kind = 3'd0;

    // halt_req pulsed in WAIT at pc=0x8
    chk("halt_addr", imem_addr, 32'h8);
    imem_ack = 1'b0;
    step();
    halt_req = 1'b1;
    step();
    halt_req = 1'b0; imem_ack = 1'b1;
    #1 chk("halt_ir_load", {31'd0, ir_load}, 32'd1);
    step();
    chk("halt_exec", {31'd0, ex_valid}, 32'd1);
    step();
    chk("halted", {31'd0, halted}, 32'd1);
    chk("halt_req_off", {31'd0, imem_req}, 32'd0);
    chk("halt_pc", pc_out, 32'hC);
    chk("halt_count", instr_count, 32'd11);
    step();
    chk("halt_hold", {31'd0, halted}, 32'd1);
    start = 1'b1; halt_req = 1'b1;
    step();
    start = 1'b0; halt_req = 1'b0;
    chk("resume_halted", {31'd0, halted}, 32'd0);

    // PC wrap from 0xFFFFFFFC
    fetch_one(32'hC);
    br_kind = 3'd1; br_target = 32'hFFFF_FFFC;
    step();
    br_kind = 3'd0;
    fetch_one(32'hFFFF_FFFC);
    step();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_fault", {31'd0, fault}, 32'd0);
    chk("wrap_pc_prev", pc_prev, 32'hFFFF_FFFC);

    // Misaligned taken target at pc=0x4
    fetch_one(32'h0);
    step();
    fetch_one(32'h4);
    br_kind = 3'd1; br_target = 32'h42;
    #1 chk("mis_taken", {31'd0, taken}, 32'd1);
    step();
    br_kind = 3'd0;
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_pc", pc_out, 32'h4);
    chk("mis_req", {31'd0, imem_req}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("mis_sticky", {31'd0, fault}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mis_rst_fault", {31'd0, fault}, 32'd0);
    chk("mis_rst_pc", pc_out, 32'h0);
    rst = 1'b1;

    // Fetch timeout
    start = 1'b1; imem_ack = 1'b0;
    step();
    start = 1'b0;
    step();
    for (int i = 1; i <= 14; i++) step();
    chk("to_still_wait", {30'd0, fault, imem_req}, 32'd1);
    step();
    chk("to_fault", {31'd0, fault}, 32'd1);
    chk("to_req", {31'd0, imem_req}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("to_sticky", {31'd0, fault}, 32'd1);
    rst = 1'b0;
    #1 rst = 1'b1;
    chk("to_rst_fault", {31'd0, fault}, 32'd0);

    // Asynchronous reset during WAIT
    start = 1'b1; imem_ack = 1'b1;
    step();
    start = 1'b0;
    fetch_one(32'h0);
    br_kind = 3'd1; br_target = 32'h80;
    step();
    br_kind = 3'd0; imem_ack = 1'b0;
    chk("arst_addr", imem_addr, 32'h80);
    step();
    chk("arst_wait_req", {31'd0, imem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_pc", pc_out, 32'h0);
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_count", instr_count, 32'd0);
    step();
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
